// File: rtl/tp_sequencer.sv
// tp_sequencer: configures and sequences the test-pattern generator.
// Optional macro TP_SEQ_WATCHDOG_EN adds a WAIT_VS timeout and O_wdt_err.
module tp_sequencer #(
  parameter int FRAMES_PER_MODE = 120,
  parameter int RST_HOLD        = 16,
  parameter int WDT_CYCLES      = 4194304
) (
  input  logic        I_pxl_clk,
  input  logic        I_rst,
  input  logic        I_vs,
  input  logic        I_req,
  input  logic [2:0]  I_req_mode,
  input  logic [1:0]  I_req_res,
  input  logic [23:0] I_req_color,
  input  logic        I_auto_en,
  output logic        O_ack,
  output logic        O_busy,
  output logic [2:0]  O_mode,
  output logic [7:0]  O_single_r,
  output logic [7:0]  O_single_g,
  output logic [7:0]  O_single_b,
  output logic [11:0] O_h_total,
  output logic [11:0] O_h_sync,
  output logic [11:0] O_h_bporch,
  output logic [11:0] O_h_res,
  output logic [11:0] O_v_total,
  output logic [11:0] O_v_sync,
  output logic [11:0] O_v_bporch,
  output logic [11:0] O_v_res,
  output logic        O_hs_pol,
  output logic        O_vs_pol,
  output logic        O_tp_rst_n,
  output logic        O_wdt_err
);

  localparam int HW = $clog2(RST_HOLD);
  localparam int FW = $clog2(FRAMES_PER_MODE + 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(RST_HOLD - 1);
  localparam logic [FW-1:0] FRM_LAST =
    FW'(FRAMES_PER_MODE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_APPLY,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] h_res;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
    logic [11:0] v_res;
    logic        hs_pol;
    logic        vs_pol;
  } timing_t;

  function automatic timing_t preset(
    input logic [1:0] r
  );
    timing_t t;
    unique case (r)
      2'd0: t = '{12'd800, 12'd96, 12'd48,
                  12'd640, 12'd525, 12'd2,
                  12'd33, 12'd480, 1'b0, 1'b0};
      2'd1: t = '{12'd1056, 12'd128, 12'd88,
                  12'd800, 12'd628, 12'd4,
                  12'd23, 12'd600, 1'b1, 1'b1};
      2'd2: t = '{12'd1650, 12'd40, 12'd220,
                  12'd1280, 12'd750, 12'd5,
                  12'd20, 12'd720, 1'b1, 1'b1};
      2'd3: t = '{12'd1344, 12'd136, 12'd160,
                  12'd1024, 12'd806, 12'd6,
                  12'd29, 12'd768, 1'b0, 1'b0};
    endcase
    return t;
  endfunction

  state_t          state;
  state_t          nxt;
  timing_t         tim_q;
  timing_t         pre;
  logic [HW-1:0]   hold_cnt;
  logic [FW-1:0]   frame_cnt;
  logic [2:0]      l_mode;
  logic [1:0]      l_res;
  logic [23:0]     l_color;
  logic [1:0]      cur_res;
  logic [2:0]      mode_nxt;
  logic            vs_act;
  logic            vs_d;
  logic            post_hold;
  logic            fs;
  logic            armed;
  logic            ack_pend;
  logic            accept;
  logic            hold_done;
  logic            auto_fs;
  logic            res_chg;
  logic            wdt_hit;

  assign pre        = preset(l_res);
  assign O_h_total  = tim_q.h_total;
  assign O_h_sync   = tim_q.h_sync;
  assign O_h_bporch = tim_q.h_bporch;
  assign O_h_res    = tim_q.h_res;
  assign O_v_total  = tim_q.v_total;
  assign O_v_sync   = tim_q.v_sync;
  assign O_v_bporch = tim_q.v_bporch;
  assign O_v_res    = tim_q.v_res;
  assign O_hs_pol   = tim_q.hs_pol;
  assign O_vs_pol   = tim_q.vs_pol;

  assign O_busy  = (state != S_IDLE);
  assign vs_act  = O_vs_pol ? I_vs : ~I_vs;
  assign fs      = vs_act & ~vs_d &
                   (state != S_HOLD) & ~post_hold;
  assign res_chg = (l_res != cur_res);
  assign auto_fs = (state == S_IDLE) & ~accept &
                   I_auto_en & fs;
  assign mode_nxt = (O_mode < 3'd3) ?
                    O_mode + 3'd1 : 3'd0;

`ifdef TP_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES);
  localparam logic [WW-1:0] WDT_LAST =
    WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt_cnt;
  logic          wdt_err;

  assign wdt_hit   = (wdt_cnt == WDT_LAST);
  assign O_wdt_err = wdt_err;

  // WAIT_VS timeout counter and sticky error flag
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      wdt_cnt <= '0;
      wdt_err <= 1'b0;
    end else if (state != S_WAIT || fs) begin
      wdt_cnt <= '0;
    end else if (wdt_hit) begin
      wdt_cnt <= '0;
      wdt_err <= 1'b1;
    end else begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  // watchdog compiled out: WAIT_VS never times out
  assign wdt_hit   = 1'b0;
  assign O_wdt_err = 1'b0 & (WDT_CYCLES != 0);
`endif

  // FSM state register; reset parks the generator in HOLD
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) state <= S_HOLD;
    else       state <= nxt;
  end

  // FSM next state and per-cycle strobes
  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    hold_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (I_req && armed) begin
          accept = 1'b1;
          nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fs || wdt_hit) nxt = S_APPLY;
      end
      S_APPLY: begin
        nxt = res_chg ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_done = 1'b1;
          nxt       = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Request latch, output apply, hold and frame counters
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      vs_d       <= 1'b1;
      post_hold  <= 1'b0;
      armed      <= 1'b0;
      ack_pend   <= 1'b0;
      hold_cnt   <= '0;
      frame_cnt  <= '0;
      l_mode     <= '0;
      l_res      <= '0;
      l_color    <= '0;
      cur_res    <= '0;
      O_ack      <= 1'b0;
      O_tp_rst_n <= 1'b0;
      O_mode     <= '0;
      O_single_r <= '0;
      O_single_g <= '0;
      O_single_b <= '0;
      tim_q      <= preset(2'd0);
    end else begin
      vs_d      <= vs_act;
      post_hold <= hold_done;
      O_ack     <= 1'b0;

      if (accept)
        armed <= 1'b0;
      else if (state == S_IDLE && !I_req)
        armed <= 1'b1;

      if (accept) begin
        l_mode  <= I_req_mode;
        l_res   <= I_req_res;
        l_color <= I_req_color;
      end

      if (!I_auto_en || accept || state == S_APPLY) begin
        frame_cnt <= '0;
      end else if (auto_fs) begin
        if (frame_cnt == FRM_LAST) begin
          frame_cnt <= '0;
          O_mode    <= mode_nxt;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      if (state == S_APPLY) begin
        O_mode     <= l_mode;
        O_single_r <= l_color[7:0];
        O_single_g <= l_color[15:8];
        O_single_b <= l_color[23:16];
        tim_q      <= pre;
        cur_res    <= l_res;
        if (res_chg) begin
          O_tp_rst_n <= 1'b0;
          hold_cnt   <= '0;
          ack_pend   <= 1'b1;
        end else begin
          O_ack <= 1'b1;
        end
      end

      if (state == S_HOLD) begin
        if (hold_done) begin
          hold_cnt   <= '0;
          O_tp_rst_n <= 1'b1;
          O_ack      <= ack_pend;
          ack_pend   <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tp_sequencer.sv
// tb_tp_sequencer: bench for tp_sequencer.
// Covers presets, hold, auto-cycle, arming and watchdog.
module tb_tp_sequencer;

  localparam int FP = 20;

  logic        clk = 1'b0;
  logic        I_rst;
  logic        I_vs;
  logic        I_req;
  logic [2:0]  I_req_mode;
  logic [1:0]  I_req_res;
  logic [23:0] I_req_color;
  logic        I_auto_en;
  logic        O_ack, O_busy;
  logic [2:0]  O_mode;
  logic [7:0]  O_single_r, O_single_g, O_single_b;
  logic [11:0] O_h_total, O_h_sync, O_h_bporch, O_h_res;
  logic [11:0] O_v_total, O_v_sync, O_v_bporch, O_v_res;
  logic        O_hs_pol, O_vs_pol, O_tp_rst_n, O_wdt_err;

  logic act;
  logic vs_run;
  int   ph;
  int   n_chk;
  int   n_fail;

  typedef struct {
    int ht, hs, hb, hr, vt, vs, vb, vr, hp, vp;
  } tm_t;

  typedef struct {
    logic [2:0]  mode;
    logic [1:0]  res;
    logic [23:0] col;
    int          low;
  } sb_t;

  sb_t sb[$];

  always #5 clk = ~clk;

  assign I_vs = O_vs_pol ? act : ~act;

  tp_sequencer #(
    .FRAMES_PER_MODE(3),
    .RST_HOLD(16),
    .WDT_CYCLES(64)
  ) dut (
    .I_pxl_clk(clk),
    .I_rst(I_rst),
    .I_vs(I_vs),
    .I_req(I_req),
    .I_req_mode(I_req_mode),
    .I_req_res(I_req_res),
    .I_req_color(I_req_color),
    .I_auto_en(I_auto_en),
    .O_ack(O_ack),
    .O_busy(O_busy),
    .O_mode(O_mode),
    .O_single_r(O_single_r),
    .O_single_g(O_single_g),
    .O_single_b(O_single_b),
    .O_h_total(O_h_total),
    .O_h_sync(O_h_sync),
    .O_h_bporch(O_h_bporch),
    .O_h_res(O_h_res),
    .O_v_total(O_v_total),
    .O_v_sync(O_v_sync),
    .O_v_bporch(O_v_bporch),
    .O_v_res(O_v_res),
    .O_hs_pol(O_hs_pol),
    .O_vs_pol(O_vs_pol),
    .O_tp_rst_n(O_tp_rst_n),
    .O_wdt_err(O_wdt_err)
  );

  function automatic tm_t ref_tm(input logic [1:0] r);
    tm_t t;
    case (r)
      2'd0: t = '{800, 96, 48, 640, 525, 2, 33, 480, 0, 0};
      2'd1: t = '{1056, 128, 88, 800, 628, 4, 23, 600, 1, 1};
      2'd2: t = '{1650, 40, 220, 1280, 750, 5, 20, 720, 1, 1};
      default: t = '{1344, 136, 160, 1024, 806, 6, 29, 768, 0, 0};
    endcase
    return t;
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // one clock; inputs and samples settle 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (vs_run) begin
      ph  = (ph == FP - 1) ? 0 : ph + 1;
      act = (ph < 3);
    end
  endtask

  task automatic wait_rise();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ph != 0 && n < 2 * FP);
  endtask

  task automatic frame();
    wait_rise();
    tick();
  endtask

  task automatic request(input logic [2:0] m,
                         input logic [1:0] r,
                         input logic [23:0] c,
                         input int low);
    sb_t e;
    e = '{m, r, c, low};
    sb.push_back(e);
    I_req_mode  = m;
    I_req_res   = r;
    I_req_color = c;
    I_req       = 1'b1;
    tick();
    I_req = 1'b0;
  endtask

  task automatic wait_ack(input int lim, input string tag);
    int  n, low;
    bit  got;
    sb_t e;
    tm_t t;
    n = 0;
    low = 0;
    got = 0;
    while (!got && n < lim) begin
      tick();
      n++;
      if (!O_tp_rst_n) low++;
      if (O_ack) got = 1;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_ack_timeout: no ack in %0d cycles",
               tag, lim);
    end else if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb_empty: ack with nothing expected",
               tag);
    end else begin
      e = sb.pop_front();
      t = ref_tm(e.res);
      check({tag, "_h_total"},  32'(O_h_total),  t.ht);
      check({tag, "_h_sync"},   32'(O_h_sync),   t.hs);
      check({tag, "_h_bporch"}, 32'(O_h_bporch), t.hb);
      check({tag, "_h_res"},    32'(O_h_res),    t.hr);
      check({tag, "_v_total"},  32'(O_v_total),  t.vt);
      check({tag, "_v_sync"},   32'(O_v_sync),   t.vs);
      check({tag, "_v_bporch"}, 32'(O_v_bporch), t.vb);
      check({tag, "_v_res"},    32'(O_v_res),    t.vr);
      check({tag, "_hs_pol"},   32'(O_hs_pol),   t.hp);
      check({tag, "_vs_pol"},   32'(O_vs_pol),   t.vp);
      check({tag, "_mode"},     32'(O_mode),  32'(e.mode));
      check({tag, "_color"},
            32'({O_single_b, O_single_g, O_single_r}),
            32'(e.col));
      check({tag, "_low_cycles"}, low, e.low);
      check({tag, "_tp_rst_n"}, 32'(O_tp_rst_n), 1);
      check({tag, "_busy"}, 32'(O_busy), 0);
    end
    tick();
    check({tag, "_ack_pulse"}, 32'(O_ack), 0);
  endtask

  task automatic rst_release(input string tag);
    int n, acks;
    I_rst = 1'b0;
    n = 0;
    acks = 0;
    while (!O_tp_rst_n && n < 100) begin
      tick();
      n++;
      if (O_ack) acks++;
    end
    tick();
    if (O_ack) acks++;
    check({tag, "_hold_len"}, n, 16);
    check({tag, "_no_ack"}, acks, 0);
    check({tag, "_busy_idle"}, 32'(O_busy), 0);
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [1:0]  res;
    logic [23:0] col;
    int          low;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   acks;
    int   exp_mode;

    n_chk       = 0;
    n_fail      = 0;
    I_rst       = 1'b1;
    I_req       = 1'b0;
    I_req_mode  = '0;
    I_req_res   = '0;
    I_req_color = '0;
    I_auto_en   = 1'b0;
    act         = 1'b0;
    vs_run      = 1'b0;
    ph          = 0;

    vt[0] = '{3'd2, 2'd0, 24'h00FF00, 0};
    vt[1] = '{3'd5, 2'd2, 24'h123456, 16};
    vt[2] = '{3'd1, 2'd2, 24'hABCDEF, 0};
    vt[3] = '{3'd3, 2'd1, 24'h0000FF, 16};
    vt[4] = '{3'd7, 2'd3, 24'hFF0000, 16};
    vt[5] = '{3'd0, 2'd0, 24'h5A5A5A, 16};

    repeat (3) tick();
    check("rst_h_total", 32'(O_h_total), 800);
    check("rst_v_res", 32'(O_v_res), 480);
    check("rst_vs_pol", 32'(O_vs_pol), 0);
    check("rst_mode", 32'(O_mode), 0);
    check("rst_busy", 32'(O_busy), 1);
    check("rst_ack", 32'(O_ack), 0);
    check("rst_tp_rst_n", 32'(O_tp_rst_n), 0);
    check("rst_wdt_err", 32'(O_wdt_err), 0);
    rst_release("por");
    tick();

    // latency: VS active level to output update
    request(3'd4, 2'd0, 24'h0000AA, 0);
    check("lat_wait_busy", 32'(O_busy), 1);
    repeat (3) tick();
    act = 1'b1;
    tick();
    check("lat_edge1_mode", 32'(O_mode), 0);
    wait_ack(1, "lat");
    act = 1'b0;
    tick();

    // free-running short frames
    ph = FP - 1;
    vs_run = 1'b1;
    foreach (vt[i]) begin
      request(vt[i].mode, vt[i].res, vt[i].col, vt[i].low);
      wait_ack(200, $sformatf("vec%0d", i));
      tick();
    end

    // auto-cycle: step on every 3rd frame start
    frame();
    I_auto_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      frame();
      exp_mode = (k / 3) % 4;
      check($sformatf("auto_f%0d", k), 32'(O_mode), exp_mode);
    end

    // request on the same edge as the stepping frame start
    frame();
    frame();
    wait_rise();
    request(3'd6, 2'd0, 24'h00FF00, 0);
    check("coll_mode_kept", 32'(O_mode), 0);
    check("coll_busy", 32'(O_busy), 1);
    wait_ack(100, "coll");
    frame();
    frame();
    check("coll_cnt_cleared", 32'(O_mode), 6);
    frame();
    check("auto_wrap_6", 32'(O_mode), 0);
    I_auto_en = 1'b0;
    tick();

    // request held high through ack
    sb.push_back('{3'd2, 2'd0, 24'h010203, 0});
    I_req_mode  = 3'd2;
    I_req_res   = 2'd0;
    I_req_color = 24'h010203;
    I_req       = 1'b1;
    wait_ack(100, "held1");
    acks = 0;
    repeat (80) begin
      tick();
      if (O_ack) acks++;
    end
    check("held_no_reaccept", acks, 0);
    I_req = 1'b0;
    tick();
    tick();
    sb.push_back('{3'd5, 2'd0, 24'h040506, 0});
    I_req_mode  = 3'd5;
    I_req_color = 24'h040506;
    I_req       = 1'b1;
    wait_ack(100, "held2");
    I_req = 1'b0;
    tick();

`ifdef TP_SEQ_WATCHDOG_EN
    begin
      int n;
      vs_run = 1'b0;
      act = 1'b0;
      tick();
      tick();
      request(3'd1, 2'd0, 24'h111111, 0);
      n = 0;
      while (!O_wdt_err && n < 200) begin
        tick();
        n++;
      end
      check("wdt_cycles", n, 64);
      check("wdt_apply_busy", 32'(O_busy), 1);
      wait_ack(1, "wdt");
      repeat (10) tick();
      check("wdt_sticky", 32'(O_wdt_err), 1);
    end
`else
    check("wdt_tied_low", 32'(O_wdt_err), 0);
`endif

    // reset mid-operation discards the pending request
    vs_run = 1'b0;
    act = 1'b0;
    tick();
    request(3'd3, 2'd1, 24'h777777, 0);
    tick();
    check("mid_busy", 32'(O_busy), 1);
    I_rst = 1'b1;
    #2;
    check("mid_async_mode", 32'(O_mode), 0);
    check("mid_async_h_total", 32'(O_h_total), 800);
    check("mid_async_tp_rst_n", 32'(O_tp_rst_n), 0);
    check("mid_async_color",
          32'({O_single_b, O_single_g, O_single_r}), 0);
    check("mid_async_wdt_err", 32'(O_wdt_err), 0);
    sb.delete();
    tick();
    rst_release("mid");
    check("mid_v_total", 32'(O_v_total), 525);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
